// File: rtl/litsoc_cpu_top_if.sv
// Simple word bus between the core and its memories.
// Macro DATA_RAM_EN (optional) adds a second instance carrying loads/stores.
// Signals:
//   addr  : byte address from master
//   wdata : write data from master
//   be    : byte enables from master
//   we    : write strobe from master
//   rdata : combinational read data from slave
interface litsoc_cpu_top_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        we;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output be, output we, input rdata);
  modport slave  (input addr, input wdata, input be, input we, output rdata);
endinterface

// File: rtl/litsoc_cpu_top.sv
// LITSoC processor top: single-cycle RV32I core plus instruction ROM.
// Optional macro DATA_RAM_EN adds a 4 KiB data RAM and LB/LH/LW/LBU/LHU/SB/SH/SW;
// without it loads and stores retire as NOPs.
// Ports:
//   clk  : system clock, all state updates on the rising edge
//   rest : asynchronous active-low reset
// Parameters:
//   ROM_DEPTH : instruction ROM depth in 32-bit words
//   RESET_PC  : PC value held during reset

// Program counter register.
module litsoc_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc_i,
  output logic [31:0] pc2if_addr_o
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc2if_addr_o <= RESET_PC;
    else        pc2if_addr_o <= next_pc_i;
  end
endmodule

// Register file: two combinational read ports, one synchronous write port.
module litsoc_regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic        rd_we_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  output logic [31:0] rs1_data_c,
  output logic [31:0] rs2_data_c
);
  logic [31:0] x_regs [0:31];

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) x_regs[i] <= '0;
    end else if (rd_we_i && (rd_addr_i != 5'd0)) begin
      x_regs[rd_addr_i] <= rd_data_i;
    end
  end

  // Reads see the pre-edge value; a same-cycle write lands at the edge.
  assign rs1_data_c = (rs1_addr_i == 5'd0) ? 32'd0 : x_regs[rs1_addr_i];
  assign rs2_data_c = (rs2_addr_i == 5'd0) ? 32'd0 : x_regs[rs2_addr_i];
endmodule

// Instruction ROM, contents loaded by simulation; word index wraps modulo depth.
module litsoc_ins_rom #(
  parameter int unsigned ROM_DEPTH = 4096
) (
  litsoc_cpu_top_if.slave bus
);
  localparam int unsigned AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

  logic [31:0] rom_mem [0:ROM_DEPTH-1];
  logic [29:0] word_addr;
  logic [AW-1:0] word_idx;
  logic unused_rom;

  assign word_addr = bus.addr[31:2];
  assign word_idx  = AW'(word_addr % 30'(ROM_DEPTH));
  assign bus.rdata = rom_mem[word_idx];
  assign unused_rom = ^{bus.addr[1:0], bus.wdata, bus.be, bus.we};
endmodule

`ifdef DATA_RAM_EN
// 1024x32 data RAM, byte enables, combinational read, not cleared by reset.
module litsoc_data_ram (
  input logic             clk,
  litsoc_cpu_top_if.slave bus
);
  logic [31:0] ram_mem [0:1023];
  logic [9:0]  word_idx;
  logic unused_ram;

  assign word_idx   = bus.addr[11:2];
  assign bus.rdata  = ram_mem[word_idx];
  assign unused_ram = ^{bus.addr[31:12], bus.addr[1:0]};

  always_ff @(posedge clk) begin
    if (bus.we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.be[b]) ram_mem[word_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end
endmodule
`endif

// Single-cycle RV32I core: fetch, decode, execute in one cycle.
module litsoc_cpu_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst_n,
  litsoc_cpu_top_if.master ibus
`ifdef DATA_RAM_EN
  ,
  litsoc_cpu_top_if.master dbus
`endif
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
`ifdef DATA_RAM_EN
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
`endif

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rd_we;
  logic [31:0] rd_data;
  logic [31:0] pc_plus4;

  litsoc_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .next_pc_i    (next_pc),
    .pc2if_addr_o (pc)
  );

  litsoc_regs u_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1_addr_i (rs1),
    .rs2_addr_i (rs2),
    .rd_we_i    (rd_we),
    .rd_addr_i  (rd),
    .rd_data_i  (rd_data),
    .rs1_data_c (rs1_data),
    .rs2_data_c (rs2_data)
  );

  // Fetch port: read-only.
  assign ibus.addr  = pc;
  assign ibus.wdata = '0;
  assign ibus.be    = '0;
  assign ibus.we    = 1'b0;
  assign instr      = ibus.rdata;

  // Field and immediate decode.
  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign funct7   = instr[31:25];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u    = {instr[31:12], 12'd0};
  assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign pc_plus4 = pc + 32'd4;

  // Shared ALU for OP and OP-IMM; alt selects SUB/SRA.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f3, input logic alt);
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      3'b000:  alu_f = alt ? (a - b) : (a + b);
      3'b001:  alu_f = a << sh;
      3'b010:  alu_f = {31'd0, $signed(a) < $signed(b)};
      3'b011:  alu_f = {31'd0, a < b};
      3'b100:  alu_f = a ^ b;
      3'b101:  alu_f = alt ? 32'($signed(a) >>> sh) : (a >> sh);
      3'b110:  alu_f = a | b;
      default: alu_f = a & b;
    endcase
  endfunction

  // Branch condition; reserved funct3 encodings never branch.
  function automatic logic br_taken_f(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3);
    case (f3)
      3'b000:  br_taken_f = (a == b);
      3'b001:  br_taken_f = (a != b);
      3'b100:  br_taken_f = ($signed(a) < $signed(b));
      3'b101:  br_taken_f = ($signed(a) >= $signed(b));
      3'b110:  br_taken_f = (a < b);
      3'b111:  br_taken_f = (a >= b);
      default: br_taken_f = 1'b0;
    endcase
  endfunction

`ifdef DATA_RAM_EN
  logic [31:0] imm_s;
  logic [31:0] ld_addr;
  logic [31:0] st_addr;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign ld_addr = rs1_data + imm_i;
  assign st_addr = rs1_data + imm_s;
  assign ld_byte = 8'(dbus.rdata >> {ld_addr[1:0], 3'b000});
  // Halfword lane is chosen by addr[1]; addr[0] is ignored (aligned down).
  assign ld_half = 16'(dbus.rdata >> {ld_addr[1], 4'b0000});
`endif

  // Execute: next PC, writeback and data-bus controls; unknown encodings are NOPs.
  always_comb begin
    next_pc = pc_plus4;
    rd_we   = 1'b0;
    rd_data = '0;
`ifdef DATA_RAM_EN
    dbus.addr  = (opcode == OPC_STORE) ? st_addr : ld_addr;
    dbus.wdata = rs2_data;
    dbus.be    = 4'b0000;
    dbus.we    = 1'b0;
`endif
    case (opcode)
      OPC_LUI: begin
        rd_we   = 1'b1;
        rd_data = imm_u;
      end
      OPC_AUIPC: begin
        rd_we   = 1'b1;
        rd_data = pc + imm_u;
      end
      OPC_JAL: begin
        rd_we   = 1'b1;
        rd_data = pc_plus4;
        next_pc = pc + imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          rd_we   = 1'b1;
          rd_data = pc_plus4;
          next_pc = (rs1_data + imm_i) & ~32'd1;
        end
      end
      OPC_BRANCH: begin
        if (br_taken_f(rs1_data, rs2_data, funct3)) next_pc = pc + imm_b;
      end
      OPC_OPIMM: begin
        if ((funct3 == 3'b001 && funct7 == 7'h00) ||
            (funct3 == 3'b101 && (funct7 == 7'h00 || funct7 == 7'h20)) ||
            (funct3 != 3'b001 && funct3 != 3'b101)) begin
          rd_we   = 1'b1;
          rd_data = alu_f(rs1_data, imm_i, funct3, (funct3 == 3'b101) && instr[30]);
        end
      end
      OPC_OP: begin
        if (funct7 == 7'h00 ||
            (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          rd_we   = 1'b1;
          rd_data = alu_f(rs1_data, rs2_data, funct3, instr[30]);
        end
      end
`ifdef DATA_RAM_EN
      OPC_LOAD: begin
        rd_we = 1'b1;
        case (funct3)
          3'b000:  rd_data = {{24{ld_byte[7]}}, ld_byte};
          3'b001:  rd_data = {{16{ld_half[15]}}, ld_half};
          3'b010:  rd_data = dbus.rdata;
          3'b100:  rd_data = {24'd0, ld_byte};
          3'b101:  rd_data = {16'd0, ld_half};
          default: rd_we   = 1'b0;
        endcase
      end
      OPC_STORE: begin
        case (funct3)
          3'b000: begin
            dbus.we    = 1'b1;
            dbus.be    = 4'b0001 << st_addr[1:0];
            dbus.wdata = {4{rs2_data[7:0]}};
          end
          3'b001: begin
            dbus.we    = 1'b1;
            dbus.be    = st_addr[1] ? 4'b1100 : 4'b0011;
            dbus.wdata = {2{rs2_data[15:0]}};
          end
          3'b010: begin
            dbus.we    = 1'b1;
            dbus.be    = 4'b1111;
          end
          default: ;
        endcase
      end
`endif
      default: ;
    endcase
  end
endmodule

// Top level: core, instruction ROM and optional data RAM.
module litsoc_cpu_top #(
  parameter int unsigned ROM_DEPTH = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rest
);
  litsoc_cpu_top_if ibus ();
`ifdef DATA_RAM_EN
  litsoc_cpu_top_if dbus ();
`endif

  litsoc_cpu_core #(.RESET_PC(RESET_PC)) u_cpu_core (
    .clk   (clk),
    .rst_n (rest),
    .ibus  (ibus.master)
`ifdef DATA_RAM_EN
    ,
    .dbus  (dbus.master)
`endif
  );

  litsoc_ins_rom #(.ROM_DEPTH(ROM_DEPTH)) u_ins_rom (
    .bus (ibus.slave)
  );

`ifdef DATA_RAM_EN
  litsoc_data_ram u_data_ram (
    .clk (clk),
    .bus (dbus.slave)
  );
`endif
endmodule

// File: tb/tb_litsoc_cpu_top.sv
// Scoreboard bench for litsoc_cpu_top: an instruction-level reference model
// predicts PC and rd after every cycle; a negedge monitor compares.
module tb_litsoc_cpu_top;
  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  logic rest = 1'b0;
  always #5 clk = ~clk;

  litsoc_cpu_top #(.ROM_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .rest (rest)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] img   [DEPTH];
  logic [31:0] m_rom [DEPTH];
  logic [31:0] m_regs[32];
  logic [31:0] m_pc;
  logic [7:0]  m_ram [4096];
  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    logic [11:0] s;
    s = 12'(imm);
    return {s[11:5], 5'(rs2), 5'(rs1), 3'(f3), s[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [12:0] b;
    b = 13'(imm);
    return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'(f3), b[4:1], b[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] op);
    return {20'(imm20), 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [20:0] j;
    j = 21'(imm);
    return {j[20], j[10:1], j[11], j[19:12], 5'(rd), 7'b1101111};
  endfunction

  // ---------------- reference model ----------------
  task automatic m_step(output exp_t e);
    logic [31:0] ins, a, b, opb, ii, is, ib, iu, ij, npc, v;
    logic [6:0] op;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2, sh;
    logic wr, taken;
    logic [11:0] ad;
    ins = m_rom[int'((m_pc >> 2) % DEPTH)];
    op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; rs1 = ins[19:15]; rs2 = ins[24:20];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'd0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    a = m_regs[rs1]; b = m_regs[rs2];
    npc = m_pc + 32'd4; wr = 1'b0; v = '0; taken = 1'b0;
    case (op)
      7'h37: begin wr = 1'b1; v = iu; end
      7'h17: begin wr = 1'b1; v = m_pc + iu; end
      7'h6F: begin wr = 1'b1; v = m_pc + 32'd4; npc = m_pc + ij; end
      7'h67: begin wr = 1'b1; v = m_pc + 32'd4; npc = (a + ii) & ~32'd1; end
      7'h63: begin
        case (f3)
          3'd0: taken = (a == b);
          3'd1: taken = (a != b);
          3'd4: taken = ($signed(a) < $signed(b));
          3'd5: taken = ($signed(a) >= $signed(b));
          3'd6: taken = (a < b);
          3'd7: taken = (a >= b);
          default: taken = 1'b0;
        endcase
        if (taken) npc = m_pc + ib;
      end
      7'h13, 7'h33: begin
        wr = 1'b1;
        opb = (op == 7'h13) ? ii : b;
        sh = opb[4:0];
        case (f3)
          3'd0: v = (op == 7'h33 && ins[30]) ? a - opb : a + opb;
          3'd1: v = a << sh;
          3'd2: v = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
          3'd3: v = (a < opb) ? 32'd1 : 32'd0;
          3'd4: v = a ^ opb;
          3'd5: v = ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
          3'd6: v = a | opb;
          default: v = a & opb;
        endcase
      end
`ifdef DATA_RAM_EN
      7'h03: begin
        ad = 12'(a + ii);
        wr = 1'b1;
        case (f3)
          3'd0: v = {{24{m_ram[ad][7]}}, m_ram[ad]};
          3'd4: v = {24'd0, m_ram[ad]};
          3'd1: v = {{16{m_ram[ad | 12'd1][7]}}, m_ram[ad | 12'd1], m_ram[ad & ~12'd1]};
          3'd5: v = {16'd0, m_ram[ad | 12'd1], m_ram[ad & ~12'd1]};
          3'd2: v = {m_ram[ad | 12'd3], m_ram[(ad & ~12'd3) + 12'd2],
                     m_ram[(ad & ~12'd3) + 12'd1], m_ram[ad & ~12'd3]};
          default: wr = 1'b0;
        endcase
      end
      7'h23: begin
        ad = 12'(a + is);
        case (f3)
          3'd0: m_ram[ad] = b[7:0];
          3'd1: begin m_ram[ad & ~12'd1] = b[7:0]; m_ram[ad | 12'd1] = b[15:8]; end
          3'd2: for (int k = 0; k < 4; k++) m_ram[(ad & ~12'd3) + 12'(k)] = b[8*k +: 8];
          default: ;
        endcase
      end
`endif
      default: ;
    endcase
    if (wr && rd != 5'd0) m_regs[rd] = v;
    m_pc = npc;
    e.pc = npc;
    e.rd = rd;
    e.val = m_regs[rd];
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check32("pc", dut.u_cpu_core.u_pc_reg.pc2if_addr_o, e.pc);
      check32($sformatf("x%0d", e.rd), dut.u_cpu_core.u_regs.x_regs[e.rd], e.val);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_reset_state();
    check32("reset_pc", dut.u_cpu_core.u_pc_reg.pc2if_addr_o, 32'h0);
    for (int r = 0; r < 32; r++)
      check32($sformatf("reset_x%0d", r), dut.u_cpu_core.u_regs.x_regs[r], 32'h0);
  endtask

  // Asserts reset mid-cycle (except at t=0), loads img, releases on a negedge.
  task automatic start_prog(input bit first);
    if (!first) begin
      @(negedge clk);
      #3 rest = 1'b0;
    end
    #1 check_reset_state();
    for (int i = 0; i < DEPTH; i++) begin
      m_rom[i] = img[i];
      dut.u_ins_rom.rom_mem[i] = img[i];
    end
    for (int r = 0; r < 32; r++) m_regs[r] = '0;
    m_pc = 32'h0;
    @(posedge clk);
    #1 check32("pc_held_in_reset", dut.u_cpu_core.u_pc_reg.pc2if_addr_o, 32'h0);
    @(negedge clk);
    rest = 1'b1;
    #1;
  endtask

  task automatic run_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      m_step(e);
      sb_q.push_back(e);
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    check32("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic check_all_regs();
    for (int r = 0; r < 32; r++)
      check32($sformatf("final_x%0d", r), dut.u_cpu_core.u_regs.x_regs[r], m_regs[r]);
  endtask

  task automatic clear_img();
    for (int i = 0; i < DEPTH; i++) img[i] = 32'h0;
  endtask

  function automatic int rreg();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    int sel, f3, f7, off;
    logic [31:0] w;
    sel = int'($urandom_range(0, 11));
    case (sel)
      0: w = enc_u(int'($urandom), rreg(), 7'h37);
      1: w = enc_u(int'($urandom), rreg(), 7'h17);
      2, 3: begin
        f3 = int'($urandom_range(0, 7));
        if (f3 == 1) w = enc_i(int'($urandom_range(0, 31)), rreg(), f3, rreg(), 7'h13);
        else if (f3 == 5)
          w = enc_i(int'($urandom_range(0, 31)) | (($urandom_range(0, 1) != 0) ? 32'h400 : 32'h0),
                    rreg(), f3, rreg(), 7'h13);
        else w = enc_i(int'($urandom), rreg(), f3, rreg(), 7'h13);
      end
      4, 5: begin
        f3 = int'($urandom_range(0, 7));
        f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        w = enc_r(f7, rreg(), rreg(), f3, rreg());
      end
      6: begin
        case ($urandom_range(0, 5))
          0: f3 = 0; 1: f3 = 1; 2: f3 = 4; 3: f3 = 5; 4: f3 = 6; default: f3 = 7;
        endcase
        off = (int'($urandom_range(0, 10)) - 5) * 4;
        w = enc_b(off, rreg(), rreg(), f3);
      end
      7: begin
        off = (int'($urandom_range(0, 16)) - 8) * 4;
        w = enc_j(off, rreg());
      end
      8: w = enc_i(int'($urandom_range(0, 255)) - 128, ($urandom_range(0, 1) != 0) ? 0 : rreg(),
                   0, rreg(), 7'h67);
      9: begin
        case ($urandom_range(0, 4))
          0: f3 = 0; 1: f3 = 1; 2: f3 = 2; 3: f3 = 4; default: f3 = 5;
        endcase
        w = enc_i(int'($urandom_range(0, 4095)), rreg(), f3, rreg(), 7'h03);
      end
      10: w = enc_s(int'($urandom_range(0, 4095)), rreg(), rreg(), int'($urandom_range(0, 2)));
      default: begin
        case ($urandom_range(0, 4))
          0: w = 32'h0000_000F;
          1: w = 32'h0000_0073;
          2: w = 32'h0010_0073;
          3: w = 32'h0000_0000;
          default: w = {$urandom_range(0, 32'h1FF_FFFF), 7'h7F};
        endcase
      end
    endcase
    return w;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 4096; i++) m_ram[i] = 8'h00;
`ifdef DATA_RAM_EN
    for (int i = 0; i < 1024; i++) dut.u_data_ram.ram_mem[i] = 32'h0;
`endif

    // ADDI chain, reset held from t=0 and released at 10 ns.
    clear_img();
    img[0] = enc_i(5, 0, 0, 1, 7'h13);
    img[1] = enc_i(-7, 1, 0, 3, 7'h13);
    img[2] = enc_r(0, 3, 1, 0, 4);
    start_prog(1'b1);
    run_cycles(3);
    check32("chain_x1", dut.u_cpu_core.u_regs.x_regs[1], 32'd5);
    check32("chain_x3", dut.u_cpu_core.u_regs.x_regs[3], 32'hFFFF_FFFE);
    check32("chain_x4", dut.u_cpu_core.u_regs.x_regs[4], 32'd3);
    check32("chain_pc", dut.u_cpu_core.u_pc_reg.pc2if_addr_o, 32'd12);

    // Write to x0 discarded.
    clear_img();
    img[0] = enc_i(1, 0, 0, 0, 7'h13);
    start_prog(1'b0);
    run_cycles(1);
    check32("x0_stays_zero", dut.u_cpu_core.u_regs.x_regs[0], 32'd0);

    // Branch loop: PC 0,4,8,12,8,12,8.
    clear_img();
    img[0] = enc_i(1, 0, 0, 5, 7'h13);
    img[1] = enc_b(8, 0, 5, 0);
    img[2] = enc_i(2, 0, 0, 6, 7'h13);
    img[3] = enc_b(-4, 0, 5, 1);
    start_prog(1'b0);
    run_cycles(6);
    check32("branch_x6", dut.u_cpu_core.u_regs.x_regs[6], 32'd2);
    check32("branch_pc", dut.u_cpu_core.u_pc_reg.pc2if_addr_o, 32'd8);

    // Jumps and upper immediates.
    clear_img();
    img[0] = enc_u(32'h12345, 7, 7'h37);
    img[1] = enc_u(1, 4, 7'h17);
    img[2] = enc_j(8, 1);
    img[3] = enc_i(0, 1, 0, 0, 7'h67);
    start_prog(1'b0);
    run_cycles(3);
    check32("lui_x7", dut.u_cpu_core.u_regs.x_regs[7], 32'h1234_5000);
    check32("auipc_x4", dut.u_cpu_core.u_regs.x_regs[4], 32'h0000_1004);
    check32("jal_x1", dut.u_cpu_core.u_regs.x_regs[1], 32'd12);
    check32("jal_pc", dut.u_cpu_core.u_pc_reg.pc2if_addr_o, 32'd16);

    // Signed/unsigned compares and shifts.
    clear_img();
    img[0] = enc_i(-1, 0, 0, 5, 7'h13);
    img[1] = enc_r(0, 0, 5, 2, 6);
    img[2] = enc_r(0, 0, 5, 3, 7);
    img[3] = enc_i(32'h404, 5, 5, 8, 7'h13);
    img[4] = enc_i(28, 5, 5, 9, 7'h13);
    start_prog(1'b0);
    run_cycles(5);
    check32("slt", dut.u_cpu_core.u_regs.x_regs[6], 32'd1);
    check32("sltu", dut.u_cpu_core.u_regs.x_regs[7], 32'd0);
    check32("srai", dut.u_cpu_core.u_regs.x_regs[8], 32'hFFFF_FFFF);
    check32("srli", dut.u_cpu_core.u_regs.x_regs[9], 32'h0000_000F);

    // PC wrap: jump to 0xFFFFFFFC, then PC+4 wraps to 0.
    clear_img();
    img[0] = enc_i(-4, 0, 0, 1, 7'h13);
    img[1] = enc_i(0, 1, 0, 0, 7'h67);
    img[DEPTH-1] = enc_i(7, 0, 0, 2, 7'h13);
    start_prog(1'b0);
    run_cycles(2);
    check32("wrap_pc_top", dut.u_cpu_core.u_pc_reg.pc2if_addr_o, 32'hFFFF_FFFC);
    run_cycles(1);
    check32("wrap_pc_zero", dut.u_cpu_core.u_pc_reg.pc2if_addr_o, 32'h0);
    check32("wrap_x2", dut.u_cpu_core.u_regs.x_regs[2], 32'd7);

    // Store/load sequence.
    clear_img();
    img[0] = enc_u(32'h80FF0, 5, 7'h37);
    img[1] = enc_i(32'h011, 5, 0, 5, 7'h13);
    img[2] = enc_s(4, 5, 0, 2);
    img[3] = enc_i(7, 0, 0, 6, 7'h03);
    img[4] = enc_i(7, 0, 4, 7, 7'h03);
    start_prog(1'b0);
    run_cycles(5);
    check32("ram_x5", dut.u_cpu_core.u_regs.x_regs[5], 32'h80FF_0011);
`ifdef DATA_RAM_EN
    check32("lb_x6", dut.u_cpu_core.u_regs.x_regs[6], 32'hFFFF_FF80);
    check32("lbu_x7", dut.u_cpu_core.u_regs.x_regs[7], 32'h0000_0080);
`else
    check32("noram_x6", dut.u_cpu_core.u_regs.x_regs[6], 32'h0);
    check32("noram_x7", dut.u_cpu_core.u_regs.x_regs[7], 32'h0);
`endif

    // Random programs against the reference model.
    for (int p = 0; p < 25; p++) begin
      clear_img();
      for (int i = 0; i < 48; i++) img[i] = rand_instr();
      start_prog(1'b0);
      run_cycles(150);
      check_all_regs();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/litsoc_cpu_top.md
# litsoc_cpu_top

Top level of the LITSoC processor: a single-cycle RV32I integer core plus its instruction ROM, driven only by clock and reset. The ROM is preloaded by simulation (`$readmemb`/`$readmemh`). The top has no functional outputs; results are observed through hierarchical register and PC state.

## Interface
- `ROM_DEPTH`, default 4096: instruction ROM depth in 32-bit words.
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `clk` input, 1 bit: single system clock; all state updates on the rising edge.
- `rest` input, 1 bit: asynchronous, active-low reset.

Fixed hierarchy, which benches probe:
- `u_ins_rom.rom_mem[0:ROM_DEPTH-1]`: 32-bit ROM array.
- `u_cpu_core.u_pc_reg.pc2if_addr_o`: current 32-bit PC.
- `u_cpu_core.u_regs.x_regs[0:31]`: 32-bit register file.

## Operation
- **Fetch:** combinational ROM read of word `pc2if_addr_o[log2(ROM_DEPTH)+1:2]`.
  - PC bits [1:0] are ignored.
  - Indices wrap modulo ROM_DEPTH.
- **Decode/execute:** happens in the same cycle as fetch. Writeback and PC update occur at the next rising edge.
- **Supported instructions (RV32I):**
  - LUI, AUIPC, JAL, JALR.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- **Arithmetic:** 32-bit, wrap-around, no overflow detection.
  - Shift amount is the low 5 bits of the operand.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
  - Immediates are sign-extended per ISA.
- **Next PC:**
  - Default: PC+4.
  - Taken branch or JAL: PC+imm.
  - JALR: (rs1+imm) & ~1.
  - JAL/JALR write PC+4 to rd.
- **Register file:**
  - x0 reads 0 always; writes to x0 are discarded.
  - Two combinational read ports, one synchronous write port.
  - A read of the register being written in the same cycle returns the old value.
- **FENCE, ECALL, EBREAK, and any unrecognized opcode:** executed as NOP (no register write, PC+4).
- **Loads/stores:** see Configuration.

## Timing
- **While `rest`=0:** PC = RESET_PC and all x_regs = 0, asynchronously. ROM contents are unaffected.
- **First fetch:** the first rising edge after `rest` deasserts executes the instruction at RESET_PC.
- **Throughput:** CPI = 1 for all instructions, including taken branches and jumps. There are no stalls or flushes.
- **Register writes:** an instruction's rd value is visible in `x_regs` after the rising edge that retires it. A dependent instruction in the next cycle reads the new value.
- **Reset mid-run:** asserting `rest` at any time immediately forces PC and registers to reset values. Any partial cycle is discarded.
- **Wrap-around:** PC+4 at 32'hFFFF_FFFC wraps to 0.

## Configuration
- `DATA_RAM_EN` **defined:**
  - Adds instance `u_data_ram`, 4 KiB (1024×32), byte addressed by the low 12 address bits, zero at power-up, not cleared by reset.
  - Supports LB/LH/LW/LBU/LHU with sign/zero extension.
  - Supports SB/SH/SW using byte enables; writes occur on the rising edge.
  - Reads are combinational, so a load retires in one cycle.
  - Misaligned halfword/word accesses use the address with its low bits cleared to alignment.
- `DATA_RAM_EN` **undefined:**
  - Load and store opcodes execute as NOP: rd is not written, PC+4.
  - No RAM is instantiated.

## Test plan
- **ADDI chain:** ROM `addi x1,x0,5; addi x3,x1,-7; add x4,x1,x3`.
  - After 3 cycles: x1=5, x3=0xFFFFFFFE, x4=3.
  - PC: 0→4→8→12.
- **Reset:** `rest`=0 at t=0, released at 10 ns.
  - PC=0 and all regs=0 during reset.
  - Writing `addi x0,x0,1` leaves x0=0.
- **Branch:** `addi x5,x0,1; beq x5,x0,+8; addi x6,x0,2; bne x5,x0,-4`.
  - x6=2.
  - PC sequence 0,4,8,12,8,12,8…
  - The not-taken BEQ advances PC by 4.
- **Jumps/upper:** `lui x7,0x12345; auipc x4,1; jal x1,+8; jalr x0,0(x1)`.
  - x7=0x12345000.
  - x4=0x1004.
  - x1=12.
  - PC after JAL = 16.
- **Signed vs unsigned compares and shifts:**
  - x5=-1: `slt x6,x5,x0` → 1; `sltu x6,x5,x0` → 0.
  - `srai x6,x5,4` → 0xFFFFFFFF; `srli x6,x5,28` → 0xF.
- **With DATA_RAM_EN:** `sw x5,4(x0); lb x6,7(x0); lbu x7,7(x0)` with x5=0x80FF0011.
  - x6=0xFFFFFF80.
  - x7=0x80.
- **Without DATA_RAM_EN:** the same sequence leaves x6 and x7 unchanged.
